// File: rtl/joy_serial_scan.sv
`default_nettype none
// ============================================================================
// joy_serial_scan : load/clock/data scanner for chained serial pads, with
//                   pad-presence detection, debounce and a per-frame strobe.
// Revision 1.0
// ============================================================================
module joy_serial_scan #(
    parameter int PLAYERS  = 2,
    parameter int BITS     = 16,
    parameter int DIV      = 24,
    parameter int GAP      = 256,
    parameter int DEBOUNCE = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    output logic                    joy_load,
    output logic                    joy_clk,
    input  logic                    joy_data,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic [PLAYERS-1:0]      present,
    output logic                    frame_done
);
    localparam int N    = PLAYERS * BITS;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int CMAX = (GAP > DIV) ? GAP : DIV;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LOW    = 3'd2,
        S_HIGH   = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_state_n;
    logic [CW-1:0]              r_cnt;
    logic [CW-1:0]              w_cnt_n;
    logic [IW-1:0]              r_idx;
    logic [IW-1:0]              w_idx_n;
    logic                       w_capture;
    logic                       w_div_end;
    logic                       r_sync_0;
    logic                       r_sync_1;
    logic [N-1:0]               r_raw;
    logic [DEBOUNCE-1:0][N-1:0] r_hist;
    logic [N-1:0]               w_agree_1;
    logic [N-1:0]               w_agree_0;
    logic [N-1:0]               w_keep;
    logic [N-1:0]               w_joy_next;
    logic [PLAYERS-1:0]         w_present;

    assign w_div_end = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
        end
    end

    // In IDLE the counter saturates at GAP-1 so en is re-tested every cycle.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + CW'(1);
        w_idx_n   = r_idx;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cnt == CW'(GAP - 1)) begin
                    w_cnt_n = r_cnt;
                    if (en) begin
                        w_state_n = S_LOAD;
                        w_cnt_n   = '0;
                    end
                end
            end
            S_LOAD: begin
                if (w_div_end) begin
                    w_state_n = S_LOW;
                    w_cnt_n   = '0;
                    w_idx_n   = '0;
                end
            end
            S_LOW: begin
                if (w_div_end) begin
                    w_capture = 1'b1;
                    w_cnt_n   = '0;
                    w_state_n = (r_idx == IW'(N - 1)) ? S_UPDATE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_div_end) begin
                    w_state_n = S_LOW;
                    w_cnt_n   = '0;
                    w_idx_n   = r_idx + IW'(1);
                end
            end
            S_UPDATE: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    // Agreement is taken over the new raw frame plus the DEBOUNCE-1 older ones.
    always_comb begin
        w_agree_1 = r_raw;
        w_agree_0 = ~r_raw;
        for (int j = 0; j < DEBOUNCE - 1; j++) begin
            w_agree_1 = w_agree_1 & r_hist[j];
            w_agree_0 = w_agree_0 & ~r_hist[j];
        end
        for (int p = 0; p < PLAYERS; p++) begin
            w_present[p]              = ~(&r_raw[p*BITS +: BITS]);
            w_keep[p*BITS +: BITS]    = {BITS{w_present[p]}};
        end
        w_joy_next = ((joystick | w_agree_1) & ~w_agree_0) & w_keep;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_0   <= 1'b0;
            r_sync_1   <= 1'b0;
            r_raw      <= '0;
            r_hist     <= '0;
            joystick   <= '0;
            present    <= '0;
            joy_load   <= 1'b0;
            joy_clk    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_sync_0   <= joy_data;
            r_sync_1   <= r_sync_0;
            joy_load   <= (w_state_n == S_LOAD);
            joy_clk    <= (w_state_n == S_HIGH);
            frame_done <= (r_state == S_UPDATE);
            if (w_capture) begin
                r_raw[r_idx] <= ~r_sync_1;
            end
            if (r_state == S_UPDATE) begin
                joystick  <= w_joy_next;
                present   <= w_present;
                r_hist[0] <= r_raw & w_keep;
                for (int j = 1; j < DEBOUNCE; j++) begin
                    r_hist[j] <= r_hist[j-1] & w_keep;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joy_serial_scan.sv
`default_nettype none
// Bench for joy_serial_scan: instance A at default parameters, instance B
// at PLAYERS=3 BITS=12 DIV=4 GAP=1 DEBOUNCE=3, each fed by a pad-chain model.
module tb_joy_serial_scan;
    localparam int PA = 2,  BA = 16, NA = 32, DIVA = 24, GAPA = 256, DBA = 2;
    localparam int PERA = GAPA + 2 * NA * DIVA + 1;
    localparam int PB = 3,  BB = 12, NB = 36, DIVB = 4,  GAPB = 1,   DBB = 3;
    localparam int PERB = GAPB + 2 * NB * DIVB + 1;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic          reset_a = 1'b0, en_a = 1'b0;
    logic          joy_load_a, joy_clk_a, joy_data_a, frame_done_a;
    logic [NA-1:0] joystick_a;
    logic [PA-1:0] present_a;
    logic [NA-1:0] pins_a = '1;
    logic [NA-1:0] sr_a = '1;
    logic          jc_prev_a = 1'b0, jl_prev_a = 1'b0;
    int            clk_pulses_a = 0, loads_a = 0;

    logic          reset_b = 1'b0, en_b = 1'b0;
    logic          joy_load_b, joy_clk_b, joy_data_b, frame_done_b;
    logic [NB-1:0] joystick_b;
    logic [PB-1:0] present_b;
    logic [NB-1:0] pins_b = '1;
    logic [NB-1:0] sr_b = '1;
    logic          jc_prev_b = 1'b0;

    logic [NB-1:0] m_joy;
    logic [PB-1:0] m_pres;
    logic [NB-1:0] m_h [DBB];

    joy_serial_scan #(.PLAYERS(PA), .BITS(BA), .DIV(DIVA), .GAP(GAPA), .DEBOUNCE(DBA)) u_dut_a (
        .clk(clk), .reset_n(reset_a), .en(en_a), .joy_load(joy_load_a), .joy_clk(joy_clk_a),
        .joy_data(joy_data_a), .joystick(joystick_a), .present(present_a), .frame_done(frame_done_a));

    joy_serial_scan #(.PLAYERS(PB), .BITS(BB), .DIV(DIVB), .GAP(GAPB), .DEBOUNCE(DBB)) u_dut_b (
        .clk(clk), .reset_n(reset_b), .en(en_b), .joy_load(joy_load_b), .joy_clk(joy_clk_b),
        .joy_data(joy_data_b), .joystick(joystick_b), .present(present_b), .frame_done(frame_done_b));

    // Pad chains: parallel load while joy_load is high, shift on joy_clk rise.
    always @(posedge clk) begin
        jc_prev_a <= joy_clk_a;
        jl_prev_a <= joy_load_a;
        jc_prev_b <= joy_clk_b;
        if (joy_clk_a && !jc_prev_a) clk_pulses_a <= clk_pulses_a + 1;
        if (joy_load_a && !jl_prev_a) loads_a <= loads_a + 1;
        if (joy_load_a) sr_a <= pins_a;
        else if (joy_clk_a && !jc_prev_a) sr_a <= {1'b0, sr_a[NA-1:1]};
        if (joy_load_b) sr_b <= pins_b;
        else if (joy_clk_b && !jc_prev_b) sr_b <= {1'b0, sr_b[NB-1:1]};
    end
    assign joy_data_a = sr_a[0];
    assign joy_data_b = sr_b[0];

    task automatic wait_fd(input bit sel_b, output int cyc, output bit ok);
        int limit;
        limit = (sel_b ? PERB : PERA) + 20;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if ((sel_b ? frame_done_b : frame_done_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic model_reset();
        m_joy  = '0;
        m_pres = '0;
        for (int j = 0; j < DBB; j++) m_h[j] = '0;
    endtask

    // One frame of B as the pads saw it: presence, then per-bit agreement count.
    task automatic model_frame(input logic [NB-1:0] pins);
        logic [NB-1:0] raw;
        int ones;
        raw = ~pins;
        for (int j = DBB - 1; j > 0; j--) m_h[j] = m_h[j-1];
        m_h[0] = raw;
        for (int p = 0; p < PB; p++) begin
            if (raw[p*BB +: BB] == {BB{1'b1}}) begin
                m_pres[p] = 1'b0;
                m_joy[p*BB +: BB] = '0;
                for (int j = 0; j < DBB; j++) m_h[j][p*BB +: BB] = '0;
            end else begin
                m_pres[p] = 1'b1;
                for (int b = p * BB; b < (p + 1) * BB; b++) begin
                    ones = 0;
                    for (int j = 0; j < DBB; j++) ones += int'(m_h[j][b]);
                    if (ones == DBB) m_joy[b] = 1'b1;
                    else if (ones == 0) m_joy[b] = 1'b0;
                end
            end
        end
    endtask

    task automatic restart_b();
        reset_b = 1'b0;
        en_b    = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic test_reset();
        int cyc;
        reset_a = 1'b0; reset_b = 1'b0; en_a = 1'b1; en_b = 1'b0;
        pins_a = {16'hFFFF, 16'hFFFE};
        repeat (3) @(negedge clk);
        checks++;
        if ({joystick_a, present_a, frame_done_a, joy_load_a, joy_clk_a} !== '0) begin
            failures++;
            $display("FAIL reset_a: got %h/%b expected all 0", joystick_a, present_a);
        end
        checks++;
        if ({joystick_b, present_b, frame_done_b, joy_load_b, joy_clk_b} !== '0) begin
            failures++;
            $display("FAIL reset_b: got %h/%b expected all 0", joystick_b, present_b);
        end
        reset_a = 1'b1; reset_b = 1'b1;
        cyc = 0;
        while (cyc < GAPA + 10 && joy_load_a !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != GAPA) begin
            failures++;
            $display("FAIL first_load: got %0d cycles expected %0d", cyc, GAPA);
        end
    endtask

    task automatic test_default();
        int cyc, p0;
        bit ok;
        wait_fd(1'b0, cyc, ok);
        checks++;
        if (!ok || joystick_a !== 32'h0 || present_a !== 2'b11) begin
            failures++;
            $display("FAIL default_f1: got ok=%0d joy=%h pres=%b expected 1/0/11", ok, joystick_a, present_a);
        end
        p0 = clk_pulses_a;
        wait_fd(1'b0, cyc, ok);
        checks++;
        if (!ok || joystick_a !== 32'h1 || present_a !== 2'b11) begin
            failures++;
            $display("FAIL default_f2: got ok=%0d joy=%h pres=%b expected 1/00000001/11", ok, joystick_a, present_a);
        end
        checks++;
        if (cyc != PERA) begin
            failures++;
            $display("FAIL default_period: got %0d expected %0d", cyc, PERA);
        end
        checks++;
        if (clk_pulses_a - p0 != NA - 1) begin
            failures++;
            $display("FAIL default_pulses: got %0d expected %0d", clk_pulses_a - p0, NA - 1);
        end
    endtask

    task automatic test_presence();
        int cyc;
        bit ok;
        pins_a = {16'hFFF0, 16'hFFFF};
        wait_fd(1'b0, cyc, ok);
        wait_fd(1'b0, cyc, ok);
        checks++;
        if (!ok || joystick_a !== 32'h000F_0000) begin
            failures++;
            $display("FAIL pres_setup: got %h expected 000f0000", joystick_a);
        end
        pins_a = {16'h0000, 16'hFFFF};
        wait_fd(1'b0, cyc, ok);
        checks++;
        if (!ok || present_a !== 2'b01 || joystick_a !== 32'h0) begin
            failures++;
            $display("FAIL pres_absent: got pres=%b joy=%h expected 01/0", present_a, joystick_a);
        end
        pins_a = {16'hFFFF, 16'hFFFF};
        wait_fd(1'b0, cyc, ok);
        checks++;
        if (!ok || present_a !== 2'b11 || joystick_a !== 32'h0) begin
            failures++;
            $display("FAIL pres_restore: got pres=%b joy=%h expected 11/0", present_a, joystick_a);
        end
    endtask

    task automatic test_reset_mid_shift();
        int cyc, p0;
        bit ok;
        pins_a = {16'hFFFF, 16'hFFFE};
        wait_fd(1'b0, cyc, ok);
        wait_fd(1'b0, cyc, ok);
        checks++;
        if (!ok || joystick_a !== 32'h1) begin
            failures++;
            $display("FAIL mid_setup: got %h expected 00000001", joystick_a);
        end
        p0 = clk_pulses_a;
        cyc = 0;
        while (cyc < PERA && clk_pulses_a < p0 + 11) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (joy_clk_a !== 1'b1) begin
            failures++;
            $display("FAIL mid_in_high: got joy_clk=%b expected 1", joy_clk_a);
        end
        #3 reset_a = 1'b0;
        #1;
        checks++;
        if ({joystick_a, present_a, frame_done_a, joy_load_a, joy_clk_a} !== '0) begin
            failures++;
            $display("FAIL mid_async_clear: got joy=%h pres=%b clk=%b expected 0", joystick_a, present_a, joy_clk_a);
        end
        @(negedge clk);
        reset_a = 1'b1;
        cyc = 0;
        while (cyc < GAPA + 10 && joy_load_a !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != GAPA) begin
            failures++;
            $display("FAIL mid_relaunch: got %0d cycles expected %0d", cyc, GAPA);
        end
    endtask

    task automatic test_en_drop();
        int cyc, snap;
        bit ok;
        cyc = 0;
        while (cyc < DIVA + 5 && joy_load_a === 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        en_a = 1'b0;
        wait_fd(1'b0, cyc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL en_drop_commit: got no frame_done expected one");
        end
        snap = loads_a;
        repeat (3 * PERA) @(negedge clk);
        checks++;
        if (loads_a != snap || joy_load_a !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_idle: got %0d loads expected 0", loads_a - snap);
        end
        en_a = 1'b1;
        wait_fd(1'b0, cyc, ok);
        checks++;
        if (!ok || loads_a != snap + 1 || joystick_a !== 32'h1) begin
            failures++;
            $display("FAIL en_resume: got ok=%0d loads=%0d joy=%h expected 1/1/00000001", ok, loads_a - snap, joystick_a);
        end
    endtask

    task automatic test_debounce();
        int cyc;
        bit ok;
        logic [NB-1:0] exp;
        restart_b();
        pins_b = '1;
        for (int f = 0; f < 9; f++) begin
            pins_b = '1;
            if (f == 2 || f >= 6) pins_b[4] = 1'b0;
            exp = (f == 8) ? 36'h10 : 36'h0;
            wait_fd(1'b1, cyc, ok);
            checks++;
            if (!ok || joystick_b !== exp || present_b !== 3'b111) begin
                failures++;
                $display("FAIL debounce_f%0d: got %h/%b expected %h/111", f, joystick_b, present_b, exp);
            end
        end
    endtask

    task automatic test_param();
        int cyc;
        bit ok;
        logic [63:0] tmp;
        logic [NB-1:0] pat;
        restart_b();
        for (int n = 0; n < 3; n++) begin
            tmp = {$urandom(), $urandom()};
            pat = tmp[NB-1:0];
            for (int p = 0; p < PB; p++) pat[p*BB] = 1'b0;
            pins_b = ~pat;
            for (int f = 0; f < DBB; f++) begin
                wait_fd(1'b1, cyc, ok);
                checks++;
                if (!ok || cyc != PERB) begin
                    failures++;
                    $display("FAIL param_period: got %0d expected %0d", cyc, PERB);
                end
            end
            checks++;
            if (joystick_b !== pat || present_b !== 3'b111) begin
                failures++;
                $display("FAIL param_map: got %h/%b expected %h/111", joystick_b, present_b, pat);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        bit ok;
        logic [63:0] tmp;
        restart_b();
        pins_b = '1;
        for (int f = 0; f < 40; f++) begin
            wait_fd(1'b1, cyc, ok);
            model_frame(pins_b);
            checks++;
            if (!ok || joystick_b !== m_joy || present_b !== m_pres) begin
                failures++;
                $display("FAIL random_f%0d: got %h/%b expected %h/%b", f, joystick_b, present_b, m_joy, m_pres);
            end
            tmp = {$urandom(), $urandom()} & {$urandom(), $urandom()};
            pins_b = pins_b ^ tmp[NB-1:0];
            for (int p = 0; p < PB; p++) begin
                case ($urandom_range(0, 7))
                    0: pins_b[p*BB +: BB] = '0;
                    1: pins_b[p*BB +: BB] = '1;
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_presence();
        test_reset_mid_shift();
        test_en_drop();
        test_debounce();
        test_param();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
